// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word/register widths and the EX/MEM bundle.
// Used by the EX/MEM latch, the MEM/WB latch and the hazard unit.
package cpu_types_pkg;

   localparam int WORD_W = 32;
   localparam int REG_W  = 5;

   typedef logic [WORD_W-1:0] word_t;
   typedef logic [REG_W-1:0]  regbits_t;

   typedef struct packed {
      logic     valid;
      word_t    alu_out;
      logic     zero;
      logic     negative;
      logic     overflow;
      word_t    store_data;
      regbits_t wsel;
      logic     regwen;
      logic     dren;
      logic     dwen;
      logic     memtoreg;
      logic     halt;
      word_t    npc;
   } exmem_t;

   // Turn a slot into a bubble: control off, data fields kept.
   function automatic exmem_t exmem_kill(input exmem_t x);
      exmem_t y;
      y          = x;
      y.valid    = 1'b0;
      y.regwen   = 1'b0;
      y.dren     = 1'b0;
      y.dwen     = 1'b0;
      y.memtoreg = 1'b0;
      y.halt     = 1'b0;
      return y;
   endfunction

endpackage

// File: rtl/ex_mem_latch.sv
// EX/MEM pipeline register with data-request drop and sticky halt.
// Optional perf counters: define EX_MEM_PERF_EN.
module ex_mem_latch
   import cpu_types_pkg::*;
(
   input  logic     CLK,
   input  logic     nRST,
   input  logic     en,
   input  logic     flush,
   input  logic     dhit,
   input  logic     ex_valid,
   input  word_t    ex_alu_out,
   input  logic     ex_zero,
   input  logic     ex_negative,
   input  logic     ex_overflow,
   input  word_t    ex_store_data,
   input  regbits_t ex_wsel,
   input  logic     ex_regwen,
   input  logic     ex_dren,
   input  logic     ex_dwen,
   input  logic     ex_memtoreg,
   input  logic     ex_halt,
   input  word_t    ex_npc,
   output logic     mem_valid,
   output word_t    mem_alu_out,
   output logic     mem_zero,
   output logic     mem_negative,
   output logic     mem_overflow,
   output word_t    mem_store_data,
   output regbits_t mem_wsel,
   output logic     mem_regwen,
   output logic     mem_dren,
   output logic     mem_dwen,
   output logic     mem_memtoreg,
   output logic     mem_halt,
   output word_t    mem_npc
`ifdef EX_MEM_PERF_EN
   ,
   output word_t    bubble_count,
   output word_t    stall_count
`endif
);

   exmem_t r;
   exmem_t ex_in;

   // Gather EX fields; an empty slot carries no control.
   always_comb begin
      ex_in            = '0;
      ex_in.valid      = ex_valid;
      ex_in.alu_out    = ex_alu_out;
      ex_in.zero       = ex_zero;
      ex_in.negative   = ex_negative;
      ex_in.overflow   = ex_overflow;
      ex_in.store_data = ex_store_data;
      ex_in.wsel       = ex_wsel;
      ex_in.regwen     = ex_regwen & ex_valid;
      ex_in.dren       = ex_dren & ex_valid;
      ex_in.dwen       = ex_dwen & ex_valid;
      ex_in.memtoreg   = ex_memtoreg & ex_valid;
      ex_in.halt       = ex_halt & ex_valid;
      ex_in.npc        = ex_npc;
   end

   // Halt freezes; flush beats capture; a hit drops a stalled request.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r <= '0;
      end else if (!r.halt) begin
         if (flush) begin
            r <= exmem_kill(r);
         end else if (en) begin
            r <= ex_in;
         end else if (dhit) begin
            r.dren <= 1'b0;
            r.dwen <= 1'b0;
         end
      end
   end

   assign mem_valid      = r.valid;
   assign mem_alu_out    = r.alu_out;
   assign mem_zero       = r.zero;
   assign mem_negative   = r.negative;
   assign mem_overflow   = r.overflow;
   assign mem_store_data = r.store_data;
   assign mem_wsel       = r.wsel;
   assign mem_regwen     = r.regwen;
   assign mem_dren       = r.dren;
   assign mem_dwen       = r.dwen;
   assign mem_memtoreg   = r.memtoreg;
   assign mem_halt       = r.halt;
   assign mem_npc        = r.npc;

`ifdef EX_MEM_PERF_EN
   logic bubble_evt;
   logic stall_evt;

   assign bubble_evt = !r.halt & (flush | (en & !ex_valid));
   assign stall_evt  = !r.halt & !en & !flush;

   // Count bubbles loaded and stalled edges until halt.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         bubble_count <= '0;
         stall_count  <= '0;
      end else begin
         if (bubble_evt) bubble_count <= bubble_count + 32'd1;
         if (stall_evt)  stall_count  <= stall_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ex_mem_latch.sv
// Randomized bench for ex_mem_latch against a behavioural model.
// Counter checks run only when EX_MEM_PERF_EN is defined.
module tb_ex_mem_latch;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        en, flush, dhit, ex_valid;
   logic [31:0] ex_alu_out, ex_store_data, ex_npc;
   logic        ex_zero, ex_negative, ex_overflow;
   logic [4:0]  ex_wsel;
   logic        ex_regwen, ex_dren, ex_dwen, ex_memtoreg, ex_halt;
   logic        mem_valid, mem_zero, mem_negative, mem_overflow;
   logic [31:0] mem_alu_out, mem_store_data, mem_npc;
   logic [4:0]  mem_wsel;
   logic        mem_regwen, mem_dren, mem_dwen, mem_memtoreg, mem_halt;
`ifdef EX_MEM_PERF_EN
   logic [31:0] bubble_count, stall_count;
`endif

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_on = 1'b0;

   always #5 CLK = ~CLK;

   ex_mem_latch dut (
      .CLK(CLK), .nRST(nRST), .en(en), .flush(flush), .dhit(dhit),
      .ex_valid(ex_valid), .ex_alu_out(ex_alu_out),
      .ex_zero(ex_zero), .ex_negative(ex_negative),
      .ex_overflow(ex_overflow), .ex_store_data(ex_store_data),
      .ex_wsel(ex_wsel), .ex_regwen(ex_regwen), .ex_dren(ex_dren),
      .ex_dwen(ex_dwen), .ex_memtoreg(ex_memtoreg), .ex_halt(ex_halt),
      .ex_npc(ex_npc),
      .mem_valid(mem_valid), .mem_alu_out(mem_alu_out),
      .mem_zero(mem_zero), .mem_negative(mem_negative),
      .mem_overflow(mem_overflow), .mem_store_data(mem_store_data),
      .mem_wsel(mem_wsel), .mem_regwen(mem_regwen),
      .mem_dren(mem_dren), .mem_dwen(mem_dwen),
      .mem_memtoreg(mem_memtoreg), .mem_halt(mem_halt),
      .mem_npc(mem_npc)
`ifdef EX_MEM_PERF_EN
      , .bubble_count(bubble_count), .stall_count(stall_count)
`endif
   );

   // Behavioural model: the instruction currently sitting in MEM.
   logic        m_valid, m_z, m_n, m_o;
   logic [31:0] m_alu, m_sd, m_npc;
   logic [4:0]  m_wsel;
   logic        m_rw, m_dr, m_dw, m_m2r, m_halt;
   logic [31:0] m_bub, m_stl;

   task automatic model_clear();
      {m_valid, m_z, m_n, m_o, m_rw, m_dr, m_dw, m_m2r, m_halt} = '0;
      m_alu = 0; m_sd = 0; m_npc = 0; m_wsel = 0;
      m_bub = 0; m_stl = 0;
   endtask

   always @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         model_clear();
      end else if (!m_halt) begin
         if (flush || (en && !ex_valid)) m_bub = m_bub + 1;
         if (!en && !flush) m_stl = m_stl + 1;
         if (flush) begin
            {m_valid, m_rw, m_dr, m_dw, m_m2r, m_halt} = '0;
         end else if (en) begin
            m_valid = ex_valid;
            m_alu = ex_alu_out; m_sd = ex_store_data; m_npc = ex_npc;
            m_wsel = ex_wsel;
            m_z = ex_zero; m_n = ex_negative; m_o = ex_overflow;
            m_rw  = ex_valid ? ex_regwen   : 1'b0;
            m_dr  = ex_valid ? ex_dren     : 1'b0;
            m_dw  = ex_valid ? ex_dwen     : 1'b0;
            m_m2r = ex_valid ? ex_memtoreg : 1'b0;
            m_halt = ex_valid ? ex_halt    : 1'b0;
         end else if (dhit) begin
            m_dr = 1'b0;
            m_dw = 1'b0;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp,
                  $time);
      end
   endtask

   // Compare every output against the model on each falling edge.
   always @(negedge CLK) begin
      if (chk_on && nRST) begin
         chk("valid", 32'(mem_valid), 32'(m_valid));
         chk("alu_out", mem_alu_out, m_alu);
         chk("flags", {29'd0, mem_zero, mem_negative, mem_overflow},
             {29'd0, m_z, m_n, m_o});
         chk("store_data", mem_store_data, m_sd);
         chk("wsel", 32'(mem_wsel), 32'(m_wsel));
         chk("ctl", {27'd0, mem_regwen, mem_dren, mem_dwen,
                     mem_memtoreg, mem_halt},
             {27'd0, m_rw, m_dr, m_dw, m_m2r, m_halt});
         chk("npc", mem_npc, m_npc);
`ifdef EX_MEM_PERF_EN
         chk("bubble_count", bubble_count, m_bub);
         chk("stall_count", stall_count, m_stl);
`endif
      end
   end

   task automatic rand_ex();
      ex_valid = 1'b1;
      ex_alu_out = $urandom; ex_store_data = $urandom;
      ex_npc = $urandom; ex_wsel = 5'($urandom);
      ex_zero = 1'($urandom); ex_negative = 1'($urandom);
      ex_overflow = 1'($urandom);
      ex_regwen = 1'($urandom); ex_dren = 1'($urandom);
      ex_dwen = 1'($urandom); ex_memtoreg = 1'($urandom);
      ex_halt = 1'b0;
   endtask

   task automatic ex_quiet();
      rand_ex();
      {ex_regwen, ex_dren, ex_dwen, ex_memtoreg} = '0;
   endtask

   task automatic do_reset();
      nRST = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      nRST = 1'b1;
   endtask

   initial begin
      nRST = 1'b0;
      {en, flush, dhit} = '0;
      rand_ex();
      ex_valid = 1'b0;
      #2;
      @(negedge CLK);
      chk("reset valid", 32'(mem_valid), 32'd0);
      chk("reset alu_out", mem_alu_out, 32'd0);
      chk("reset wsel", 32'(mem_wsel), 32'd0);
      chk("reset halt", 32'(mem_halt), 32'd0);
      @(negedge CLK);
      nRST = 1'b1;
      chk_on = 1'b1;

      // First capture
      ex_quiet();
      en = 1; ex_alu_out = 32'h10; ex_wsel = 5'd8; ex_regwen = 1;
      @(negedge CLK);
      chk("cap alu_out", mem_alu_out, 32'h10);
      chk("cap wsel", 32'(mem_wsel), 32'd8);
      chk("cap regwen", 32'(mem_regwen), 32'd1);

      // Stall three cycles with changing inputs
      en = 0;
      for (int i = 0; i < 3; i++) begin
         rand_ex();
         @(negedge CLK);
      end
      chk("stall alu_out", mem_alu_out, 32'h10);
      chk("stall wsel", 32'(mem_wsel), 32'd8);
`ifdef EX_MEM_PERF_EN
      chk("stall_count=3", stall_count, 32'd3);
`endif

      // Flush beats enable
      ex_quiet();
      en = 1; flush = 1; ex_dwen = 1; ex_alu_out = 32'hdead;
      @(negedge CLK);
      chk("flush valid", 32'(mem_valid), 32'd0);
      chk("flush dwen", 32'(mem_dwen), 32'd0);
      chk("flush alu_out", mem_alu_out, 32'h10);
`ifdef EX_MEM_PERF_EN
      chk("bubble_count=1", bubble_count, 32'd1);
`endif
      flush = 0;

      // Load hit while stalled, then hit with a new capture
      ex_quiet();
      ex_dren = 1; ex_alu_out = 32'h20;
      @(negedge CLK);
      chk("load dren", 32'(mem_dren), 32'd1);
      en = 0; dhit = 1;
      @(negedge CLK);
      chk("hit drop dren", 32'(mem_dren), 32'd0);
      chk("hit alu_out", mem_alu_out, 32'h20);
      en = 1; ex_alu_out = 32'h30;
      @(negedge CLK);
      chk("hit+en dren", 32'(mem_dren), 32'd1);
      chk("hit+en alu_out", mem_alu_out, 32'h30);
      dhit = 0;

      // Invalid slot
      ex_quiet();
      ex_valid = 0; ex_regwen = 1; ex_dwen = 1;
      @(negedge CLK);
      chk("inv regwen", 32'(mem_regwen), 32'd0);
      chk("inv dwen", 32'(mem_dwen), 32'd0);
`ifdef EX_MEM_PERF_EN
      chk("bubble_count=2", bubble_count, 32'd2);
`endif

      // Halt, then try to disturb it
      ex_quiet();
      ex_halt = 1; ex_alu_out = 32'h40; ex_regwen = 1;
      @(negedge CLK);
      chk("halt set", 32'(mem_halt), 32'd1);
      rand_ex();
      ex_alu_out = 32'h50; en = 1; flush = 1; dhit = 1;
      repeat (3) @(negedge CLK);
      chk("halt hold", 32'(mem_halt), 32'd1);
      chk("halt alu_out", mem_alu_out, 32'h40);
      chk("halt regwen", 32'(mem_regwen), 32'd1);
      {en, flush, dhit} = '0;

      // Reset asserted mid-cycle clears at once
      @(posedge CLK);
      #2 nRST = 1'b0;
      #1;
      chk("async halt", 32'(mem_halt), 32'd0);
      chk("async alu_out", mem_alu_out, 32'd0);
      chk("async regwen", 32'(mem_regwen), 32'd0);
      @(negedge CLK);
      nRST = 1'b1;

      // Randomized segments, reset between them
      for (int s = 0; s < 6; s++) begin
         for (int c = 0; c < 400; c++) begin
            rand_ex();
            ex_valid = ($urandom_range(0, 3) != 0);
            ex_halt = ($urandom_range(0, 149) == 0);
            en = 1'($urandom);
            flush = ($urandom_range(0, 5) == 0);
            dhit = 1'($urandom);
            @(negedge CLK);
         end
         {en, flush, dhit} = '0;
         do_reset();
      end

      chk_on = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ex_mem_latch.md
# ex_mem_latch

EX/MEM pipeline register of the five-stage pipelined CPU, directly downstream of the execute-stage ALU. Captures the ALU result and flags, store data, destination register and memory/writeback control each time the pipeline advances. Holds, flushes or bubbles on hazard-unit command. Owns the data-memory request lifetime: it drops the read/write request after a data hit so a stalled access is never reissued. Also holds the sticky halt that drains the pipeline.

## Interface
Parameters:
- none; widths come from `cpu_types_pkg` (`word_t` = 32 bits, `regbits_t` = 5 bits).

Ports:
- `CLK` in 1: pipeline clock, rising edge.
- `nRST` in 1: asynchronous, active-low reset.
- `en` in 1: advance; capture EX fields at this edge.
- `flush` in 1: insert bubble; has priority over `en`.
- `dhit` in 1: data memory completed the current MEM-stage access.
- `ex_valid` in 1: EX slot holds a real instruction.
- `ex_alu_out` in 32: ALU OUTPUT.
- `ex_zero`, `ex_negative`, `ex_overflow` in 1 each: ALU flags.
- `ex_store_data` in 32: forwarded rt value for stores.
- `ex_wsel` in 5: destination register.
- `ex_regwen`, `ex_dren`, `ex_dwen`, `ex_memtoreg`, `ex_halt` in 1 each: control.
- `ex_npc` in 32: PC+4 of the EX instruction, used for JAL link.
- `mem_*` out: registered copies of every `ex_*` field above, same widths.
- `bubble_count`, `stall_count` out 32 each: present only with `EX_MEM_PERF_EN`.

## Operation
- Reset (`nRST`=0, immediate): all `mem_*` outputs are 0, including `mem_valid`, `mem_halt`, data and `mem_wsel`. Counters are 0.
- Priority at each rising edge:
  1. `mem_halt`=1: hold all outputs; ignore `en`, `flush` and EX inputs.
  2. `flush`=1: `mem_valid`, `mem_regwen`, `mem_dren`, `mem_dwen`, `mem_memtoreg` and `mem_halt` become 0. Data fields (`alu_out`, `store_data`, `wsel`, `npc`, flags) hold their values.
  3. `en`=1: capture every `ex_*` field. If `ex_valid`=0, the control bits (`regwen`, `dren`, `dwen`, `memtoreg`, `halt`) are forced to 0 regardless of their inputs.
  4. otherwise: hold, except for the request-drop rule below.
- Request drop: `dhit`=1 while `en`=0 and `flush`=0 clears `mem_dren` and `mem_dwen` at the edge. All other fields are held.
- If `dhit` and `en` are both 1 at the same edge, the capture wins; the new instruction's request is loaded.
- Halt: the edge that captures `ex_halt`=1 with `ex_valid`=1 sets `mem_halt`. It stays set until `nRST`, and downstream sees a stable final state.
- No arithmetic on data; flags pass through unchanged.

## Timing
- Latency: 1 cycle, EX inputs to `mem_*` outputs.
- All outputs are driven directly from flops; there is no combinational path from inputs to outputs.
- `mem_dren` / `mem_dwen` fall the cycle after the `dhit` edge. Memory must treat a request that is still high in the `dhit` cycle as the same access.
- Reset asserted mid-stall clears outputs immediately. The first capture after release needs `en`=1.

## Configuration
- `EX_MEM_PERF_EN` defined:
  - `bubble_count` increments on every edge that loads `mem_valid`=0, via a flush or via `en` with `ex_valid`=0.
  - `stall_count` increments on every edge with `en`=0, `flush`=0 and `mem_halt`=0.
  - Both counters wrap at 2^32 and freeze once `mem_halt`=1.
- Not defined: both ports and their counter logic are absent.

## Structure
- `cpu_types_pkg` holds:
  - `word_t` and `regbits_t`.
  - a packed struct `exmem_t` grouping all captured fields, shared with the MEM/WB latch and the hazard unit.
- Single module, no sub-module; the register is one `exmem_t` flop plus the request-drop and halt logic.

## Test plan
- Reset: drive `nRST` low mid-cycle → all outputs 0 immediately. Release, then `en`=1 with `ex_alu_out`=32'h0000_0010, `ex_wsel`=5'd8, `ex_regwen`=1 → next cycle `mem_alu_out`=32'h10, `mem_wsel`=8, `mem_regwen`=1.
- Stall: load an instruction, then `en`=0 for 3 cycles with changing EX inputs → outputs unchanged. With perf enabled, `stall_count`=3.
- Flush priority: `en`=1 and `flush`=1 with `ex_dwen`=1 → `mem_valid`=0, `mem_dwen`=0, `mem_alu_out` unchanged.
- Load hit while stalled: `mem_dren`=1, `en`=0, `dhit`=1 for one cycle → `mem_dren`=0 next cycle and `mem_alu_out` held. `dhit` with `en`=1 and new `ex_dren`=1 → `mem_dren` stays 1.
- Invalid slot: `en`=1, `ex_valid`=0, `ex_regwen`=1, `ex_dwen`=1 → `mem_regwen`=0, `mem_dwen`=0. With perf enabled, `bubble_count` increments by 1.
- Halt: capture `ex_halt`=1 with `ex_valid`=1, then `en`=1 with new data and `flush`=1 → all outputs frozen, `mem_halt`=1 until reset.
